vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4; the number of clk cycles per pixel (100 MHz clk to 25 MHz pixel rate); legal range 2..16.
REQ-002 SHALL have parameters H_VISIBLE 640, H_FP 16, H_SYNC 96, H_BP 48; the horizontal timing in pixels (H_TOTAL = 800).
REQ-003 SHALL have parameters V_VISIBLE 480, V_FP 10, V_SYNC 2, V_BP 33; the vertical timing in lines (V_TOTAL = 525).
REQ-004 SHALL have port clk, input, 1 bit; the system clock. All logic is clocked on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit; asynchronous, active-high reset.
REQ-006 SHALL have port pix_en, output, 1 bit; the pixel-rate enable strobe.
REQ-007 SHALL have port hCount, output, 10 bits; the current pixel column (0..H_TOTAL-1, visible columns 0..H_VISIBLE-1).
REQ-008 SHALL have port vCount, output, 10 bits; the current line (0..V_TOTAL-1, visible lines 0..V_VISIBLE-1).
REQ-009 SHALL have port bright, output, 1 bit; high while the current pixel is visible.
REQ-010 SHALL have port hSync, output, 1 bit; the active-low horizontal sync.
REQ-011 SHALL have port vSync, output, 1 bit; the active-low vertical sync.
REQ-012 SHALL have port line_tick, output, 1 bit; a one-clk pulse at the start of each line.
REQ-013 SHALL have port frame_tick, output, 1 bit; a one-clk pulse at the start of vertical blanking, used as the game-logic update strobe.
REQ-014 SHALL have port frame_count, output, 8 bits; the count of completed frames.

Function
REQ-015 SHALL contain a divider counter div that counts 0..CLK_DIV-1 and wraps.
REQ-016 SHALL assert pix_en, registered, for exactly one clk cycle out of every CLK_DIV cycles: in the cycle when div equals CLK_DIV-1.
REQ-017 SHALL change hCount and vCount only on clk edges where pix_en is high; they SHALL hold their values otherwise.
REQ-018 SHALL advance counters as follows:
- hCount increments by 1.
- At H_TOTAL-1, hCount wraps to 0 and vCount increments by 1.
- At (H_TOTAL-1, V_TOTAL-1), both counters wrap to 0.
REQ-019 SHALL register bright, hSync, vSync, line_tick and frame_tick from the next-state counter values, so they are cycle-aligned with the hCount/vCount they describe; a one-cycle lag is not allowed.
REQ-020 SHALL drive bright = (hCount < H_VISIBLE) AND (vCount < V_VISIBLE).
REQ-021 SHALL drive hSync = 0 exactly while hCount is in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1], i.e. [656, 751].
REQ-022 SHALL drive vSync = 0 exactly while vCount is in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1], i.e. [490, 491]; vSync is a whole-line signal and changes only together with a hCount wrap to 0.
REQ-023 SHALL assert line_tick for one clk cycle, in the cycle the outputs first show hCount = 0; it SHALL be low in all other cycles.
REQ-024 SHALL assert frame_tick for one clk cycle, in the cycle the outputs first show (hCount, vCount) = (0, V_VISIBLE); it SHALL be low in all other cycles.
REQ-025 SHALL increment frame_count, modulo 256, in the same cycle frame_tick asserts; 255 wraps to 0.
REQ-026 SHALL keep all counter arithmetic in 10 bits; parameter combinations with a total above 1023 are illegal and SHALL NOT be supported.

Reset
REQ-027 SHALL, while reset is high, hold the following values:
- div = 0, pix_en = 0
- hCount = H_TOTAL-1 (799), vCount = V_TOTAL-1 (524)
- bright = 0, hSync = 1, vSync = 1
- line_tick = 0, frame_tick = 0, frame_count = 0
REQ-028 SHALL, on reset assertion mid-frame, force all outputs to the REQ-027 values immediately (asynchronously), without waiting for a clk edge.
REQ-029 SHALL, after reset is released, produce the first pix_en on the CLK_DIV-th rising clk edge; on that same edge the outputs become (0, 0), with bright = 1 and line_tick = 1.

Verification
REQ-030 SHALL be verified by the following directed scenarios:
- Reset release, CLK_DIV = 4: pix_en high on edges 4, 8, 12, ...; at edge 4, hCount = 0, vCount = 0, bright = 1, line_tick = 1; no counter change on any non-pix_en edge.
- One full line: bright falls when hCount goes 639 -> 640; hSync low for exactly 96 pix_en steps (hCount 656..751); at 799 -> 0, vCount increments and line_tick pulses for one clk.
- One full frame: 800 x 525 = 420000 pix_en pulses; vSync low for exactly 1600 pix_en steps (vCount 490..491); frame_tick pulses exactly once, at (0, 480), and frame_count goes 0 -> 1.
- Frame-count wrap: run 256 frames and check frame_count returns to 0; the counter period is 256 frames.
- Mid-frame reset: assert reset at (hCount, vCount) = (300, 200) between clk edges; outputs immediately show (799, 524), bright = 0, hSync = vSync = 1; after release, timing restarts exactly as in the reset-release scenario.
- Parameter override CLK_DIV = 2: pix_en on every second edge; the frame length is 840000 clk cycles.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate enable, raster counters and
// registered sync/blanking/tick outputs aligned with the counters they describe.
module vga_timing_gen #(
   parameter int unsigned CLK_DIV   = 4,
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33
) (
   input  logic       clk,
   input  logic       reset,
   output logic       pix_en,
   output logic [9:0] hCount,
   output logic [9:0] vCount,
   output logic       bright,
   output logic       hSync,
   output logic       vSync,
   output logic       line_tick,
   output logic       frame_tick,
   output logic [7:0] frame_count
);

   localparam int unsigned CNT_W        = 10;
   localparam int unsigned FC_W         = 8;
   localparam int unsigned DIV_W        = $clog2(CLK_DIV);
   localparam int unsigned H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
   localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

   logic [DIV_W-1:0] div;
   logic             tick_c;
   logic [CNT_W-1:0] h_next_c;
   logic [CNT_W-1:0] v_next_c;
   logic             bright_next_c;
   logic             hsync_next_c;
   logic             vsync_next_c;
   logic             line_next_c;
   logic             frame_next_c;

   // Next raster position and the output values that will describe it.
   always_comb begin
      tick_c   = (div == DIV_W'(CLK_DIV - 1));
      h_next_c = hCount;
      v_next_c = vCount;
      if (hCount == CNT_W'(H_TOTAL - 1)) begin
         h_next_c = '0;
         if (vCount == CNT_W'(V_TOTAL - 1)) begin
            v_next_c = '0;
         end else begin
            v_next_c = vCount + CNT_W'(1);
         end
      end else begin
         h_next_c = hCount + CNT_W'(1);
      end
      bright_next_c = (h_next_c < CNT_W'(H_VISIBLE)) && (v_next_c < CNT_W'(V_VISIBLE));
      hsync_next_c  = !((h_next_c >= CNT_W'(H_SYNC_START)) && (h_next_c <= CNT_W'(H_SYNC_END)));
      vsync_next_c  = !((v_next_c >= CNT_W'(V_SYNC_START)) && (v_next_c <= CNT_W'(V_SYNC_END)));
      line_next_c   = (h_next_c == '0);
      frame_next_c  = (h_next_c == '0) && (v_next_c == CNT_W'(V_VISIBLE));
   end

   // Reset parks the raster on the last pixel so the first step lands on (0,0).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div         <= '0;
         pix_en      <= 1'b0;
         hCount      <= CNT_W'(H_TOTAL - 1);
         vCount      <= CNT_W'(V_TOTAL - 1);
         bright      <= 1'b0;
         hSync       <= 1'b1;
         vSync       <= 1'b1;
         line_tick   <= 1'b0;
         frame_tick  <= 1'b0;
         frame_count <= '0;
      end else begin
         pix_en     <= tick_c;
         line_tick  <= 1'b0;
         frame_tick <= 1'b0;
         if (tick_c) begin
            div        <= '0;
            hCount     <= h_next_c;
            vCount     <= v_next_c;
            bright     <= bright_next_c;
            hSync      <= hsync_next_c;
            vSync      <= vsync_next_c;
            line_tick  <= line_next_c;
            frame_tick <= frame_next_c;
            if (frame_next_c) begin
               frame_count <= frame_count + FC_W'(1);
            end
         end else begin
            div <= div + DIV_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing for reset release and one
// full line, reduced timing (8x6 raster) for frame, wrap, mid-frame reset and CLK_DIV=2.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_d, rst_s4, rst_s2;

   logic       d_pix, d_br, d_hs, d_vs, d_lt, d_ft;
   logic [9:0] d_h, d_v;
   logic [7:0] d_fc;
   logic       a_pix, a_br, a_hs, a_vs, a_lt, a_ft;
   logic [9:0] a_h, a_v;
   logic [7:0] a_fc;
   logic       b_pix, b_br, b_hs, b_vs, b_lt, b_ft;
   logic [9:0] b_h, b_v;
   logic [7:0] b_fc;

   int checks   = 0;
   int failures = 0;

   vga_timing_gen u_dflt (
      .clk(clk), .reset(rst_d), .pix_en(d_pix), .hCount(d_h), .vCount(d_v),
      .bright(d_br), .hSync(d_hs), .vSync(d_vs), .line_tick(d_lt),
      .frame_tick(d_ft), .frame_count(d_fc)
   );

   // Reduced raster: H 4/1/2/1 (total 8, hSync low at 5..6), V 3/1/1/1 (total 6, vSync low at 4)
   vga_timing_gen #(
      .CLK_DIV(4), .H_VISIBLE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
   ) u_s4 (
      .clk(clk), .reset(rst_s4), .pix_en(a_pix), .hCount(a_h), .vCount(a_v),
      .bright(a_br), .hSync(a_hs), .vSync(a_vs), .line_tick(a_lt),
      .frame_tick(a_ft), .frame_count(a_fc)
   );

   vga_timing_gen #(
      .CLK_DIV(2), .H_VISIBLE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
   ) u_s2 (
      .clk(clk), .reset(rst_s2), .pix_en(b_pix), .hCount(b_h), .vCount(b_v),
      .bright(b_br), .hSync(b_hs), .vSync(b_vs), .line_tick(b_lt),
      .frame_tick(b_ft), .frame_count(b_fc)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      int         pix_steps, hs_low, br_fall_h, hs_first, hs_last, lt_cnt, hold_viol;
      bit         done;
      logic [9:0] ph, pv;
      logic       pvs;
      int         pe4, vs4, hs4, br4, lt4, ft4, ft4_edge, ft4_h, ft4_v, vs_viol, hold4;
      int         ft2_n, ft2_e1, ft2_e2, fc255;

      rst_d = 1'b1; rst_s4 = 1'b1; rst_s2 = 1'b1;
      repeat (3) @(negedge clk);

      // Reset values
      chk("rst_pix", 32'(d_pix), 0);
      chk("rst_h", 32'(d_h), 799);
      chk("rst_v", 32'(d_v), 524);
      chk("rst_bright", 32'(d_br), 0);
      chk("rst_hsync", 32'(d_hs), 1);
      chk("rst_vsync", 32'(d_vs), 1);
      chk("rst_line_tick", 32'(d_lt), 0);
      chk("rst_frame_tick", 32'(d_ft), 0);
      chk("rst_frame_count", 32'(d_fc), 0);
      chk("rst_small_h", 32'(a_h), 7);
      chk("rst_small_v", 32'(a_v), 5);

      // Release default instance: first pix_en on edge 4 with (0,0)
      rst_d = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         @(posedge clk); #1;
         chk("rel_pix_en", 32'(d_pix), (e == 4) ? 1 : 0);
         if (e < 4) chk("rel_hold_h", 32'(d_h), 799);
      end
      chk("rel_h", 32'(d_h), 0);
      chk("rel_v", 32'(d_v), 0);
      chk("rel_bright", 32'(d_br), 1);
      chk("rel_line_tick", 32'(d_lt), 1);
      @(posedge clk); #1;
      chk("rel_line_tick_one_clk", 32'(d_lt), 0);
      chk("rel_pix_one_clk", 32'(d_pix), 0);

      // One full default line
      pix_steps = 0; hs_low = 0; br_fall_h = -1; hs_first = -1; hs_last = -1;
      lt_cnt = 0; hold_viol = 0; done = 1'b0; ph = d_h; pv = d_v;
      for (int c = 0; c < 4000 && !done; c++) begin
         @(posedge clk); #1;
         if (!d_pix && (d_h !== ph || d_v !== pv)) hold_viol++;
         if (d_pix) begin
            pix_steps++;
            if (!d_hs) begin
               hs_low++;
               if (hs_first < 0) hs_first = int'(d_h);
               hs_last = int'(d_h);
            end
            if (!d_br && br_fall_h < 0) br_fall_h = int'(d_h);
         end
         if (d_lt) begin
            lt_cnt++;
            done = 1'b1;
         end
         ph = d_h; pv = d_v;
      end
      chk("line_done", 32'(done), 1);
      chk("line_pix_steps", 32'(pix_steps), 800);
      chk("line_bright_fall_h", 32'(br_fall_h), 640);
      chk("line_hsync_low_steps", 32'(hs_low), 96);
      chk("line_hsync_first", 32'(hs_first), 656);
      chk("line_hsync_last", 32'(hs_last), 751);
      chk("line_wrap_h", 32'(d_h), 0);
      chk("line_wrap_v", 32'(d_v), 1);
      chk("line_hold_viol", 32'(hold_viol), 0);
      @(posedge clk); #1;
      chk("line_tick_low_after", 32'(d_lt), 0);

      // Reduced-raster frame on CLK_DIV=4 and CLK_DIV=2 instances
      @(negedge clk);
      rst_s4 = 1'b0; rst_s2 = 1'b0;
      pe4 = 0; vs4 = 0; hs4 = 0; br4 = 0; lt4 = 0; ft4 = 0; ft4_edge = -1;
      ft4_h = -1; ft4_v = -1; vs_viol = 0; hold4 = 0; pvs = 1'b1; ph = a_h; pv = a_v;
      ft2_n = 0; ft2_e1 = -1; ft2_e2 = -1;
      for (int e = 1; e <= 196; e++) begin
         @(posedge clk); #1;
         if (e == 1) chk("s2_pix_edge1", 32'(b_pix), 0);
         if (e == 2) begin
            chk("s2_pix_edge2", 32'(b_pix), 1);
            chk("s2_h_edge2", 32'(b_h), 0);
            chk("s2_line_tick_edge2", 32'(b_lt), 1);
         end
         if (a_pix) begin
            pe4++;
            if (!a_vs) vs4++;
            if (!a_hs) hs4++;
            if (a_br) br4++;
         end
         if (a_lt) lt4++;
         if (a_ft) begin
            ft4++; ft4_edge = e; ft4_h = int'(a_h); ft4_v = int'(a_v);
         end
         if (a_vs !== pvs && a_h !== 10'd0) vs_viol++;
         if (!a_pix && (a_h !== ph || a_v !== pv)) hold4++;
         pvs = a_vs; ph = a_h; pv = a_v;
         if (b_ft) begin
            ft2_n++;
            if (ft2_n == 1) ft2_e1 = e;
            if (ft2_n == 2) ft2_e2 = e;
         end
      end
      chk("frm_pix_pulses", 32'(pe4), 49);
      chk("frm_vsync_low_steps", 32'(vs4), 8);
      chk("frm_hsync_low_steps", 32'(hs4), 12);
      chk("frm_bright_steps", 32'(br4), 13);
      chk("frm_line_ticks", 32'(lt4), 7);
      chk("frm_frame_ticks", 32'(ft4), 1);
      chk("frm_tick_edge", 32'(ft4_edge), 100);
      chk("frm_tick_h", 32'(ft4_h), 0);
      chk("frm_tick_v", 32'(ft4_v), 3);
      chk("frm_frame_count", 32'(a_fc), 1);
      chk("frm_vsync_mid_line", 32'(vs_viol), 0);
      chk("frm_hold_viol", 32'(hold4), 0);
      chk("s2_first_tick_edge", 32'(ft2_e1), 50);
      chk("s2_frame_len", 32'(ft2_e2 - ft2_e1), 96);

      // Frame-count wrap after 256 frames (CLK_DIV=2 instance)
      fc255 = -1;
      for (int c = 0; c < 30000 && ft2_n < 256; c++) begin
         @(posedge clk); #1;
         if (b_ft) begin
            ft2_n++;
            if (ft2_n == 255) fc255 = int'(b_fc);
         end
      end
      chk("wrap_ticks_seen", 32'(ft2_n), 256);
      chk("wrap_fc_255", 32'(fc255), 255);
      chk("wrap_fc_0", 32'(b_fc), 0);

      // Mid-frame asynchronous reset of CLK_DIV=4 instance at (2,1)
      done = 1'b0;
      for (int c = 0; c < 500 && !done; c++) begin
         @(posedge clk); #1;
         if (a_h == 10'd2 && a_v == 10'd1) done = 1'b1;
      end
      chk("mid_found", 32'(done), 1);
      chk("mid_bright_before", 32'(a_br), 1);
      #2;
      rst_s4 = 1'b1;
      #1;
      chk("mid_h", 32'(a_h), 7);
      chk("mid_v", 32'(a_v), 5);
      chk("mid_bright", 32'(a_br), 0);
      chk("mid_hsync", 32'(a_hs), 1);
      chk("mid_vsync", 32'(a_vs), 1);
      chk("mid_pix", 32'(a_pix), 0);
      chk("mid_fc", 32'(a_fc), 0);
      @(negedge clk);
      @(negedge clk);
      rst_s4 = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         @(posedge clk); #1;
         chk("mid_rel_pix_en", 32'(a_pix), (e == 4) ? 1 : 0);
         if (e < 4) chk("mid_rel_hold_h", 32'(a_h), 7);
      end
      chk("mid_rel_h", 32'(a_h), 0);
      chk("mid_rel_v", 32'(a_v), 0);
      chk("mid_rel_bright", 32'(a_br), 1);
      chk("mid_rel_line_tick", 32'(a_lt), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
